// File: rtl/core_sequencer_if.sv
// Host/array-facing bundle for core_sequencer.
// Handshake: the host holds start high for one cycle while the sequencer is
// idle (busy==0), with the pass parameters stable in that cycle. The sequencer
// raises busy the following cycle and keeps it high until the one-cycle done
// pulse, during which busy is already low. ofifo_valid is a level; every
// ofifo_rd pulse pops one OFIFO row, and only follows a cycle in which
// ofifo_valid was sampled high.
interface core_sequencer_if #(
    parameter int addr_bw = 11,
    parameter int kij_bw  = 4,
    parameter int nij_bw  = 11
) ();
    logic               start;
    logic               mode;
    logic [kij_bw-1:0]  num_kij;
    logic [nij_bw-1:0]  num_nij;
    logic [addr_bw-1:0] w_base;
    logic [addr_bw-1:0] x_base;
    logic [addr_bw-1:0] p_base;
    logic               ofifo_valid;

    logic               busy;
    logic               done;
    logic               xmem_cen;
    logic               xmem_wen;
    logic [addr_bw-1:0] xmem_addr;
    logic               l0_wr;
    logic               ififo_wr;
    logic               load;
    logic               execute;
    logic               ofifo_rd;
    logic               psum_cen;
    logic               psum_wen;
    logic [addr_bw-1:0] psum_addr;
    logic [kij_bw-1:0]  kij_idx;
    logic [2:0]         dbg_state;

    modport master (
        output start, mode, num_kij, num_nij, w_base, x_base, p_base, ofifo_valid,
        input  busy, done, xmem_cen, xmem_wen, xmem_addr, l0_wr, ififo_wr, load,
               execute, ofifo_rd, psum_cen, psum_wen, psum_addr, kij_idx, dbg_state
    );

    modport slave (
        input  start, mode, num_kij, num_nij, w_base, x_base, p_base, ofifo_valid,
        output busy, done, xmem_cen, xmem_wen, xmem_addr, l0_wr, ififo_wr, load,
               execute, ofifo_rd, psum_cen, psum_wen, psum_addr, kij_idx, dbg_state
    );
endinterface

// File: rtl/core_sequencer.sv
// Convolution-pass sequencer for the 2D array core. Walks weight load, PE
// load, activation streaming, execute and OFIFO drain for every kernel
// position, in weight-stationary (mode 0) or output-stationary (mode 1) order.
// All outputs come straight from flops; XMem-consuming strobes trail the
// matching read enable by one cycle to cover the SRAM read latency.
module core_sequencer #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int kij_bw  = 4,
    parameter int nij_bw  = 11
) (
    input  logic             clk,
    input  logic             reset,
    core_sequencer_if.slave  bus
);

    // Counter width covers num_nij + row + col execute cycles.
    localparam int CW = nij_bw + 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W  = 3'd1,
        S_LOAD_PE = 3'd2,
        S_EXEC_X  = 3'd3,
        S_EXEC    = 3'd4,
        S_DRAIN   = 3'd5,
        S_FIN     = 3'd6
    } state_t;

    state_t             state_q;
    logic               mode_q;
    logic [kij_bw-1:0]  num_kij_q;
    logic [nij_bw-1:0]  num_nij_q;
    logic [addr_bw-1:0] x_base_q;
    logic [addr_bw-1:0] w_ptr_q;      // next weight address, runs across kij
    logic [addr_bw-1:0] p_kbase_q;    // PSUM base of the current kij block
    logic [kij_bw-1:0]  k_q;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      rd_cnt_q;
    logic [CW-1:0]      wr_cnt_q;
    logic               xdest_q;      // 1: in-flight XMem read targets IFIFO

    logic               busy_q;
    logic               done_q;
    logic               xmem_cen_q;
    logic [addr_bw-1:0] xmem_addr_q;
    logic               l0_wr_q;
    logic               ififo_wr_q;
    logic               load_q;
    logic               execute_q;
    logic               ofifo_rd_q;
    logic               psum_cen_q;
    logic               psum_wen_q;
    logic [addr_bw-1:0] psum_addr_q;

    logic               last_kij_d;
    logic [CW-1:0]      drain_tgt_d;
    logic [CW-1:0]      exec_last_d;
    logic [CW-1:0]      nij_last_d;

    assign last_kij_d  = (k_q == num_kij_q - kij_bw'(1));
    assign drain_tgt_d = mode_q ? CW'(row) : CW'(num_nij_q);
    assign exec_last_d = CW'(num_nij_q) + CW'(row + col - 1);
    assign nij_last_d  = CW'(num_nij_q) - CW'(1);

    // Sequencer FSM with all control outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            num_kij_q   <= '0;
            num_nij_q   <= '0;
            x_base_q    <= '0;
            w_ptr_q     <= '0;
            p_kbase_q   <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            xdest_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            xmem_cen_q  <= 1'b1;
            xmem_addr_q <= '0;
            l0_wr_q     <= 1'b0;
            ififo_wr_q  <= 1'b0;
            load_q      <= 1'b0;
            execute_q   <= 1'b0;
            ofifo_rd_q  <= 1'b0;
            psum_cen_q  <= 1'b1;
            psum_wen_q  <= 1'b1;
            psum_addr_q <= '0;
        end else begin
            done_q     <= 1'b0;
            xmem_cen_q <= 1'b1;
            load_q     <= 1'b0;
            execute_q  <= 1'b0;
            ofifo_rd_q <= 1'b0;
            psum_cen_q <= 1'b1;
            psum_wen_q <= 1'b1;
            // XMem Q is valid the cycle after the enable; steer it by target.
            l0_wr_q    <= ~xmem_cen_q & ~xdest_q;
            ififo_wr_q <= ~xmem_cen_q &  xdest_q;
            // Each OFIFO pop is written to PSUM on the following cycle.
            if (ofifo_rd_q) begin
                psum_cen_q  <= 1'b0;
                psum_wen_q  <= 1'b0;
                psum_addr_q <= p_kbase_q + addr_bw'(wr_cnt_q);
                wr_cnt_q    <= wr_cnt_q + CW'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        mode_q    <= bus.mode;
                        num_kij_q <= bus.num_kij;
                        num_nij_q <= bus.num_nij;
                        x_base_q  <= bus.x_base;
                        w_ptr_q   <= bus.w_base;
                        p_kbase_q <= bus.p_base;
                        k_q       <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        if (bus.num_kij == '0 || bus.num_nij == '0)
                            state_q <= S_FIN;
                        else
                            state_q <= S_LOAD_W;
                    end
                end
                S_LOAD_W: begin
                    xmem_cen_q  <= 1'b0;
                    xmem_addr_q <= w_ptr_q;
                    xdest_q     <= mode_q;
                    w_ptr_q     <= w_ptr_q + addr_bw'(1);
                    if (cnt_q == CW'(col - 1)) begin
                        cnt_q   <= '0;
                        state_q <= mode_q ? S_EXEC_X : S_LOAD_PE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_LOAD_PE: begin
                    load_q <= 1'b1;
                    if (cnt_q == CW'(row + col - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_EXEC_X;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_EXEC_X: begin
                    xmem_cen_q  <= 1'b0;
                    xmem_addr_q <= x_base_q + addr_bw'(cnt_q);
                    xdest_q     <= 1'b0;
                    if (cnt_q == nij_last_d) begin
                        cnt_q   <= '0;
                        state_q <= S_EXEC;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_EXEC: begin
                    execute_q <= 1'b1;
                    if (cnt_q == exec_last_d) begin
                        cnt_q <= '0;
                        if (mode_q && !last_kij_d) begin
                            k_q     <= k_q + kij_bw'(1);
                            state_q <= S_LOAD_W;
                        end else begin
                            rd_cnt_q <= '0;
                            wr_cnt_q <= '0;
                            state_q  <= S_DRAIN;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (bus.ofifo_valid && rd_cnt_q < drain_tgt_d) begin
                        ofifo_rd_q <= 1'b1;
                        rd_cnt_q   <= rd_cnt_q + CW'(1);
                    end
                    // Leave on the edge that issues the final PSUM write.
                    if (ofifo_rd_q && wr_cnt_q == drain_tgt_d - CW'(1)) begin
                        if (!mode_q && !last_kij_d) begin
                            k_q       <= k_q + kij_bw'(1);
                            p_kbase_q <= p_kbase_q + addr_bw'(num_nij_q);
                            state_q   <= S_LOAD_W;
                        end else begin
                            state_q <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.xmem_cen  = xmem_cen_q;
    assign bus.xmem_wen  = 1'b1;
    assign bus.xmem_addr = xmem_addr_q;
    assign bus.l0_wr     = l0_wr_q;
    assign bus.ififo_wr  = ififo_wr_q;
    assign bus.load      = load_q;
    assign bus.execute   = execute_q;
    assign bus.ofifo_rd  = ofifo_rd_q;
    assign bus.psum_cen  = psum_cen_q;
    assign bus.psum_wen  = psum_wen_q;
    assign bus.psum_addr = psum_addr_q;
    assign bus.kij_idx   = k_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: builds the expected XMem read stream, strobe
// counts and PSUM write stream of a pass from its parameters, then watches
// the DUT outputs cycle by cycle and compares the collected streams.
module tb_core_sequencer;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int BUDGET = 20000;

  logic clk;
  logic reset;
  int total;
  int bad;

  core_sequencer_if bus ();

  core_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] a11(input int v);
    return v[10:0];
  endfunction

  // XMem read event: {kij, to_ififo, addr}
  function automatic logic [15:0] mk_x(input int k, input bit d, input int a);
    return {k[3:0], d, a[10:0]};
  endfunction

  task automatic check_reset(input string tag);
    check_eq({tag, "_ctrl"}, {bus.busy, bus.done, bus.xmem_cen, bus.xmem_wen, bus.psum_cen,
                              bus.psum_wen, bus.l0_wr, bus.ififo_wr, bus.load, bus.execute,
                              bus.ofifo_rd}, 11'h1E0);
    check_eq({tag, "_xaddr"}, bus.xmem_addr, 0);
    check_eq({tag, "_paddr"}, bus.psum_addr, 0);
    check_eq({tag, "_kij"}, bus.kij_idx, 0);
  endtask

  // driver + monitor for one pass, followed by stream comparison
  task automatic run_pass(input string nm, input bit md, input int nk, input int nn,
                          input int wb, input int xb, input int pb, input int vpat,
                          input bit poke);
    logic [15:0] exp_q[$];
    logic [15:0] act_q[$];
    logic [10:0] exp_p_q[$];
    logic [10:0] act_p_q[$];
    int exp_load, exp_exec;
    int loads, execs, rds, dones, done_cyc, stray, strobe_bad, wen_bad, rd_bad, pw_bad;
    int post_bad, busy0;
    bit pend, fin;
    logic [10:0] pend_addr;
    logic [3:0] pend_kij;

    exp_load = 0;
    exp_exec = 0;
    if (nk > 0 && nn > 0) begin
      for (int k = 0; k < nk; k++) begin
        for (int i = 0; i < COL; i++) exp_q.push_back(mk_x(k, md, wb + k * COL + i));
        for (int i = 0; i < nn; i++) exp_q.push_back(mk_x(k, 1'b0, xb + i));
        if (!md) exp_load += ROW + COL;
        exp_exec += nn + ROW + COL;
        if (!md) for (int j = 0; j < nn; j++) exp_p_q.push_back(a11(pb + k * nn + j));
      end
      if (md) for (int j = 0; j < ROW; j++) exp_p_q.push_back(a11(pb + j));
    end

    loads = 0; execs = 0; rds = 0; dones = 0; done_cyc = -1; stray = 0; strobe_bad = 0;
    wen_bad = 0; rd_bad = 0; pw_bad = 0; post_bad = 0; busy0 = 0;
    pend = 1'b0; fin = 1'b0; pend_addr = '0; pend_kij = '0;

    @(negedge clk);
    bus.mode = md;
    bus.num_kij = nk[3:0];
    bus.num_nij = nn[10:0];
    bus.w_base = a11(wb);
    bus.x_base = a11(xb);
    bus.p_base = a11(pb);
    bus.ofifo_valid = 1'b0;
    bus.start = 1'b1;

    for (int cyc = 0; cyc < BUDGET && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 0) busy0 = int'(bus.busy);
      if (pend) begin
        act_q.push_back({pend_kij, bus.ififo_wr, pend_addr});
        if ((bus.l0_wr ^ bus.ififo_wr) !== 1'b1) strobe_bad++;
      end else if (bus.l0_wr || bus.ififo_wr) begin
        stray++;
      end
      pend = !bus.xmem_cen;
      pend_addr = bus.xmem_addr;
      pend_kij = bus.kij_idx;
      if (bus.xmem_wen !== 1'b1) wen_bad++;
      if (bus.load) loads++;
      if (bus.execute) execs++;
      if (bus.ofifo_rd) begin
        rds++;
        if (!bus.ofifo_valid) rd_bad++;
      end
      if (!bus.psum_cen) begin
        act_p_q.push_back(bus.psum_addr);
        if (bus.psum_wen) pw_bad++;
      end else if (!bus.psum_wen) begin
        pw_bad++;
      end
      if (bus.done) begin
        dones++;
        done_cyc = cyc;
        fin = 1'b1;
        if (bus.busy) post_bad++;
      end
      bus.start = poke && (cyc == 0);
      case (vpat)
        0: bus.ofifo_valid = 1'b1;
        1: bus.ofifo_valid = (cyc % 3 == 0);
        default: bus.ofifo_valid = ($urandom_range(0, 1) == 1);
      endcase
    end
    bus.start = 1'b0;
    bus.ofifo_valid = 1'b0;
    if (!fin) check_eq({nm, "_timeout"}, 0, 1);

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.busy || bus.done || !bus.xmem_cen || !bus.psum_cen || bus.l0_wr
          || bus.ififo_wr || bus.load || bus.execute || bus.ofifo_rd) post_bad++;
    end

    check_eq({nm, "_busy_start"}, busy0, 1);
    check_eq({nm, "_xrd_cnt"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check_eq($sformatf("%s_xrd%0d", nm, i), act_q[i], exp_q[i]);
    check_eq({nm, "_strobe"}, strobe_bad, 0);
    check_eq({nm, "_stray"}, stray, 0);
    check_eq({nm, "_xwen"}, wen_bad, 0);
    check_eq({nm, "_load"}, loads, exp_load);
    check_eq({nm, "_exec"}, execs, exp_exec);
    check_eq({nm, "_pw_cnt"}, act_p_q.size(), exp_p_q.size());
    for (int i = 0; i < exp_p_q.size() && i < act_p_q.size(); i++)
      check_eq($sformatf("%s_pw%0d", nm, i), act_p_q[i], exp_p_q[i]);
    check_eq({nm, "_pwen"}, pw_bad, 0);
    check_eq({nm, "_rd_cnt"}, rds, exp_p_q.size());
    check_eq({nm, "_rd_valid"}, rd_bad, 0);
    check_eq({nm, "_done"}, dones, 1);
    check_eq({nm, "_post"}, post_bad, 0);
    if (nk == 0 || nn == 0) check_eq({nm, "_done_lat"}, done_cyc, 1);
  endtask

  // abort a WS pass once execute has been seen for three cycles
  task automatic run_abort();
    int ex;
    int quiet_bad;
    ex = 0;
    quiet_bad = 0;
    @(negedge clk);
    bus.mode = 1'b0;
    bus.num_kij = 4'd2;
    bus.num_nij = 11'd3;
    bus.w_base = 11'd0;
    bus.x_base = 11'd64;
    bus.p_base = 11'd0;
    bus.ofifo_valid = 1'b1;
    bus.start = 1'b1;
    for (int cyc = 0; cyc < 2000 && ex < 3; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.execute) ex++;
    end
    check_eq("abort_reach_exec", ex, 3);
    reset = 1'b0;
    @(negedge clk);
    check_reset("abort");
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.busy || bus.done || !bus.xmem_cen || !bus.psum_cen || bus.l0_wr
          || bus.load || bus.execute || bus.ofifo_rd) quiet_bad++;
    end
    bus.ofifo_valid = 1'b0;
    check_eq("abort_quiet", quiet_bad, 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.num_kij = '0;
    bus.num_nij = '0;
    bus.w_base = '0;
    bus.x_base = '0;
    bus.p_base = '0;
    bus.ofifo_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    reset = 1'b1;

    run_pass("ws1", 1'b0, 1, 4, 0, 64, 0, 0, 1'b0);
    run_pass("ws2", 1'b0, 2, 3, 0, 64, 100, 0, 1'b1);
    run_pass("os3", 1'b0 | 1'b1, 3, 2, 16, 64, 300, 0, 1'b0);
    run_pass("ws_tog", 1'b0, 2, 5, 8, 200, 40, 1, 1'b0);
    run_pass("os_tog", 1'b1, 2, 3, 0, 500, 700, 1, 1'b1);
    run_abort();
    run_pass("post_abort", 1'b0, 2, 3, 0, 64, 100, 0, 1'b0);
    run_pass("zero_nij", 1'b0, 2, 0, 0, 0, 0, 0, 1'b1);
    run_pass("zero_kij", 1'b1, 0, 5, 0, 0, 0, 0, 1'b1);
    run_pass("wrap", 1'b0, 2, 4, 2040, 2046, 2045, 2, 1'b0);
    for (int r = 0; r < 5; r++) begin
      run_pass($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)),
               int'($urandom_range(1, 4)), int'($urandom_range(1, 20)),
               int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
               int'($urandom_range(0, 2047)), 2, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
